// File: rtl/serial_addsub_nand.sv
// Bit-serial WIDTH-bit adder/subtractor: one NAND full-add cell, carry/borrow held in a flop, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADDSUB_OVF_EN.
module serial_addsub_nand #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout_bout
`ifdef SERIAL_ADDSUB_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic [WIDTH-2:0] sh_q;
    logic [CW-1:0]    cnt_q;
    logic             mode_q, c_q, busy_q, done_q, cout_q;

    logic ai, bi, ax;
    logic n1, n2, n3, x, n5, n6, n7, s;
    logic bit_d, carry_d;
    logic [WIDTH-1:0] word_d;

    function automatic logic nand2(input logic p, input logic q);
        return ~(p & q);
    endfunction

    // Subtraction reuses the adder cell: borrow-out equals the carry of (~a) + b + borrow-in,
    // and the difference bit is the complement of that cell's sum.
    always_comb begin
        ai      = a_q[cnt_q];
        bi      = b_q[cnt_q];
        ax      = mode_q ? ai : ~ai;
        n1      = nand2(ax, bi);
        n2      = nand2(ax, n1);
        n3      = nand2(bi, n1);
        x       = nand2(n2, n3);
        n5      = nand2(x, c_q);
        n6      = nand2(x, n5);
        n7      = nand2(c_q, n5);
        s       = nand2(n6, n7);
        carry_d = nand2(n1, n5);
        bit_d   = mode_q ? s : ~s;
        word_d  = {bit_d, sh_q};
    end

`ifdef SERIAL_ADDSUB_OVF_EN
    logic ovf_q, ovf_d;
    always_comb begin
        ovf_d = 1'b0;
        if (mode_q)
            ovf_d = (a_q[MSB] == b_q[MSB]) && (word_d[MSB] != a_q[MSB]);
        else
            ovf_d = (a_q[MSB] != b_q[MSB]) && (word_d[MSB] != a_q[MSB]);
    end
    assign ovf = ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            cnt_q    <= '0;
            mode_q   <= 1'b0;
            c_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_RUN: begin
                    sh_q <= word_d[WIDTH-1:1];
                    c_q  <= carry_d;
                    if (cnt_q == LAST) begin
                        result_q <= word_d;
                        cout_q   <= carry_d;
`ifdef SERIAL_ADDSUB_OVF_EN
                        ovf_q    <= ovf_d;
`endif
                        done_q   <= 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
            // The edge leaving DONE also accepts a new request so back-to-back ops lose no cycle.
            if (start && (state_q != S_RUN)) begin
                a_q     <= a;
                b_q     <= b;
                mode_q  <= mode;
                c_q     <= 1'b0;
                cnt_q   <= '0;
                busy_q  <= 1'b1;
                state_q <= S_RUN;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign cout_bout = cout_q;

endmodule

// File: tb/tb_serial_addsub_nand.sv
// Directed bench for serial_addsub_nand: WIDTH=8 vectors, reset abort, WIDTH=2 exhaustive back-to-back.
module tb_serial_addsub_nand;
    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, mode;
    logic [7:0] a, b, result;
    logic       busy, done, cout_bout;
    logic       start2, mode2;
    logic [1:0] a2, b2, result2;
    logic       busy2, done2, cout2;
`ifdef SERIAL_ADDSUB_OVF_EN
    logic       ovf, ovf2;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    serial_addsub_nand #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .cout_bout(cout_bout)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf)
`endif
    );

    serial_addsub_nand #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .mode(mode2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .result(result2), .cout_bout(cout2)
`ifdef SERIAL_ADDSUB_OVF_EN
        , .ovf(ovf2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One WIDTH=8 operation; poke re-requests with new operands mid-RUN, which must be ignored.
    task automatic run8(input string tag, input logic m, input logic [7:0] ta, input logic [7:0] tb_,
                        input logic poke, input logic [7:0] er, input logic ec, input logic eo);
        int  n, busy_cnt, pulses;
        bit  seen;
        @(negedge clk);
        mode = m; a = ta; b = tb_; start = 1'b1;
        n = 0; busy_cnt = 0; seen = 0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (poke && n == 3) begin start = 1'b1; a = 8'hAA; b = 8'h55; mode = ~m; end
            if (poke && n == 4) start = 1'b0;
            if (done) seen = 1;
            else if (busy) busy_cnt++;
        end
        chk({tag, "/latency"}, n, 9);
        chk({tag, "/busy_cycles"}, busy_cnt, 8);
        chk({tag, "/result"}, {24'd0, result}, {24'd0, er});
        chk({tag, "/cout_bout"}, {31'd0, cout_bout}, {31'd0, ec});
`ifdef SERIAL_ADDSUB_OVF_EN
        chk({tag, "/ovf"}, {31'd0, ovf}, {31'd0, eo});
`endif
        pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({tag, "/extra_done"}, pulses, 0);
        chk({tag, "/busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int         n, pulses;
        logic [4:0] iv;
        logic [2:0] e3;

        rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0;
        start2 = 1'b0; mode2 = 1'b0; a2 = '0; b2 = '0;
        #1;
        chk("rst/busy", {31'd0, busy}, 0);
        chk("rst/done", {31'd0, done}, 0);
        chk("rst/result", {24'd0, result}, 0);
        chk("rst/cout", {31'd0, cout_bout}, 0);
`ifdef SERIAL_ADDSUB_OVF_EN
        chk("rst/ovf", {31'd0, ovf}, 0);
`endif
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        run8("sub05_03", 1'b0, 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        run8("sub03_05", 1'b0, 8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        run8("addFF_01", 1'b1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("add10_20", 1'b1, 8'h10, 8'h20, 1'b1, 8'h30, 1'b0, 1'b0);
        run8("add7F_01", 1'b1, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("add01_01", 1'b1, 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        run8("addFF_FF", 1'b1, 8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, 1'b0);
        run8("sub00_01", 1'b0, 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);

        // Abort sub 0x80-0x01 with reset once bit 4 has been processed.
        @(negedge clk);
        mode = 1'b0; a = 8'h80; b = 8'h01; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort/busy", {31'd0, busy}, 0);
        chk("abort/done", {31'd0, done}, 0);
        chk("abort/result", {24'd0, result}, 0);
        chk("abort/cout", {31'd0, cout_bout}, 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk("abort/no_done", pulses, 0);
        chk("abort/result_held", {24'd0, result}, 0);
        run8("sub80_01", 1'b0, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);

        // WIDTH=2 exhaustive; start stays high so each request lands on the first legal edge.
        @(negedge clk);
        for (int i = 0; i < 32; i++) begin
            iv = i[4:0];
            mode2 = iv[4]; a2 = iv[3:2]; b2 = iv[1:0]; start2 = 1'b1;
            if (mode2) e3 = {1'b0, a2} + {1'b0, b2};
            else       e3 = {1'b0, a2} - {1'b0, b2};
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done2 && n < 10);
            chk($sformatf("w2/%0d/latency", i), n, 3);
            chk($sformatf("w2/%0d/result", i), {30'd0, result2}, {30'd0, e3[1:0]});
            chk($sformatf("w2/%0d/cout", i), {31'd0, cout2}, {31'd0, e3[2]});
        end
        start2 = 1'b0;
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
